// File: rtl/lpc_pkg.sv
// Shared LPC target definitions: FSM phases and the fixed nibble codes seen on LAD.
package lpc_pkg;

  typedef enum logic [3:0] {
    IDLE, CYCTYPE, ADDR0, ADDR1, ADDR2, ADDR3,
    WDATA0, WDATA1, HTAR0, HTAR1, SYNC,
    RDATA0, RDATA1, TTAR0, TTAR1
  } LpcState;

  localparam logic [3:0] START_NIB  = 4'h0;
  localparam logic [3:0] CYC_IORD   = 4'h0;
  localparam logic [3:0] CYC_IOWR   = 4'h2;
  localparam logic [3:0] SYNC_READY = 4'h0;
  localparam logic [3:0] TAR_NIB    = 4'hF;

endpackage

// File: rtl/lpc_io_target.sv
// LPC I/O-cycle target: decodes host I/O reads/writes into a small register window
// and answers with a zero-wait SYNC. The state names the bus phase of the current clock.
module lpc_io_target
  import lpc_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'h0700,
  parameter int          WIN_BITS  = 5
) (
  input  logic       LpcClock,
  input  logic       PciReset,
  input  logic       LFRAME_N,
  input  logic [3:0] LAD_I,
  output logic [3:0] LAD_O,
  output logic       LAD_OE,
  input  logic [7:0] RdData,
  output logic [7:0] Addr,
  output logic       Wr,
  output logic [7:0] DataWrSW,
  output logic       Rd
);

  LpcState     state;
  logic [11:0] addrShift;
  logic [3:0]  dataLo;
  logic [3:0]  rdHigh;
  logic        isWrite;
  logic [15:0] fullAddr;
  logic        hit;

  // The last address nibble is still on the pins during ADDR3.
  assign fullAddr = {addrShift, LAD_I};
  assign hit      = (fullAddr[15:WIN_BITS] == BASE_ADDR[15:WIN_BITS]);

  always_ff @(posedge LpcClock or negedge PciReset) begin
    if (!PciReset) begin
      state     <= IDLE;
      LAD_OE    <= 1'b0;
      LAD_O     <= TAR_NIB;
      Addr      <= 8'h00;
      DataWrSW  <= 8'h00;
      Wr        <= 1'b0;
      Rd        <= 1'b0;
      addrShift <= 12'h000;
      dataLo    <= 4'h0;
      rdHigh    <= 4'h0;
      isWrite   <= 1'b0;
    end else begin
      Wr <= 1'b0;
      Rd <= 1'b0;
      if (!LFRAME_N) begin
        // START restarts from any phase; any other nibble with LFRAME_N low is an abort.
        state  <= (LAD_I == START_NIB) ? CYCTYPE : IDLE;
        LAD_OE <= 1'b0;
        LAD_O  <= TAR_NIB;
      end else begin
        case (state)
          IDLE: state <= IDLE;
          CYCTYPE: begin
            if (LAD_I == CYC_IORD) begin
              isWrite <= 1'b0;
              state   <= ADDR0;
            end else if (LAD_I == CYC_IOWR) begin
              isWrite <= 1'b1;
              state   <= ADDR0;
            end else begin
              state <= IDLE;
            end
          end
          ADDR0: begin addrShift <= {addrShift[7:0], LAD_I}; state <= ADDR1; end
          ADDR1: begin addrShift <= {addrShift[7:0], LAD_I}; state <= ADDR2; end
          ADDR2: begin addrShift <= {addrShift[7:0], LAD_I}; state <= ADDR3; end
          ADDR3: begin
            if (hit) begin
              Addr  <= 8'(fullAddr[WIN_BITS-1:0]);
              state <= isWrite ? WDATA0 : HTAR0;
            end else begin
              state <= IDLE;
            end
          end
          WDATA0: begin dataLo <= LAD_I; state <= WDATA1; end
          WDATA1: begin DataWrSW <= {LAD_I, dataLo}; state <= HTAR0; end
          HTAR0:  state <= HTAR1;
          HTAR1: begin
            LAD_OE <= 1'b1;
            LAD_O  <= SYNC_READY;
            Wr     <= isWrite;
            Rd     <= !isWrite;
            state  <= SYNC;
          end
          SYNC: begin
            if (isWrite) begin
              LAD_O <= TAR_NIB;
              state <= TTAR0;
            end else begin
              LAD_O  <= RdData[3:0];
              rdHigh <= RdData[7:4];
              state  <= RDATA0;
            end
          end
          RDATA0: begin LAD_O <= rdHigh; state <= RDATA1; end
          RDATA1: begin LAD_O <= TAR_NIB; state <= TTAR0; end
          TTAR0:  begin LAD_OE <= 1'b0; state <= TTAR1; end
          TTAR1:  state <= IDLE;
          default: begin
            LAD_OE <= 1'b0;
            state  <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lpc_io_target.sv
// Bench for lpc_io_target: host-side cycle driver, strobe scoreboard and per-clock LAD trace.
module tb_lpc_io_target;

  logic       LpcClock = 1'b0;
  logic       PciReset = 1'b0;
  logic       LFRAME_N = 1'b1;
  logic [3:0] LAD_I = 4'hF;
  logic [3:0] LAD_O;
  logic       LAD_OE;
  logic [7:0] RdData;
  logic [7:0] Addr;
  logic       Wr;
  logic [7:0] DataWrSW;
  logic       Rd;

  logic [7:0] regFile [0:255];
  assign RdData = regFile[Addr];

  always #15 LpcClock = ~LpcClock;

  lpc_io_target dut (
    .LpcClock(LpcClock), .PciReset(PciReset), .LFRAME_N(LFRAME_N),
    .LAD_I(LAD_I), .LAD_O(LAD_O), .LAD_OE(LAD_OE), .RdData(RdData),
    .Addr(Addr), .Wr(Wr), .DataWrSW(DataWrSW), .Rd(Rd)
  );

  typedef struct {
    bit         isWr;
    logic [7:0] addr;
    logic [7:0] data;
    int         cyc;
  } Event;

  Event       expQ[$];
  Event       obsQ[$];
  logic       oeTrace[$];
  logic [3:0] ladTrace[$];
  int         cycleNo = 0;
  int         passCnt = 0;
  int         totalCnt = 0;
  logic [7:0] lastAddr = 8'h00;
  logic [7:0] lastData = 8'h00;

  function automatic bit isHit(input logic [15:0] a);
    return a[15:5] == 11'h038;
  endfunction

  // One LPC clock: record what the target shows this clock, then present the host nibble.
  task automatic tick(input logic frame, input logic [3:0] lad);
    @(negedge LpcClock);
    cycleNo++;
    if (Wr) obsQ.push_back('{1'b1, Addr, DataWrSW, cycleNo});
    if (Rd) obsQ.push_back('{1'b0, Addr, 8'h00, cycleNo});
    oeTrace.push_back(LAD_OE);
    ladTrace.push_back(LAD_O);
    LFRAME_N = frame;
    LAD_I    = lad;
  endtask

  task automatic doWrite(input logic [15:0] a, input logic [7:0] d, output int startCyc);
    startCyc = cycleNo + 1;
    if (isHit(a)) begin
      expQ.push_back('{1'b1, {3'b000, a[4:0]}, d, startCyc + 10});
      lastAddr = {3'b000, a[4:0]};
      lastData = d;
    end
    tick(1'b0, 4'h0);
    tick(1'b1, 4'h2);
    for (int i = 3; i >= 0; i--) tick(1'b1, a[i*4 +: 4]);
    tick(1'b1, d[3:0]);
    tick(1'b1, d[7:4]);
    repeat (5) tick(1'b1, 4'hF);
  endtask

  task automatic doRead(input logic [15:0] a, input int nTicks, output int startCyc);
    startCyc = cycleNo + 1;
    if (isHit(a)) begin
      expQ.push_back('{1'b0, {3'b000, a[4:0]}, 8'h00, startCyc + 8});
      lastAddr = {3'b000, a[4:0]};
    end
    tick(1'b0, 4'h0);
    tick(1'b1, 4'h0);
    for (int i = 3; i >= 0; i--) tick(1'b1, a[i*4 +: 4]);
    repeat (nTicks - 6) tick(1'b1, 4'hF);
  endtask

  function automatic int oeCount(input int fromCyc, input int toCyc);
    int n = 0;
    for (int c = fromCyc; c <= toCyc; c++) n += int'(oeTrace[c-1]);
    return n;
  endfunction

  task automatic test_reset;
    tick(1'b1, 4'hF);
    tick(1'b1, 4'hF);
    totalCnt++; if (LAD_OE !== 1'b0) $display("FAIL rst_oe: got %b want 0", LAD_OE); else passCnt++;
    totalCnt++; if (LAD_O !== 4'hF) $display("FAIL rst_lad: got %h want f", LAD_O); else passCnt++;
    totalCnt++; if (Addr !== 8'h00) $display("FAIL rst_addr: got %h want 00", Addr); else passCnt++;
    totalCnt++; if (DataWrSW !== 8'h00) $display("FAIL rst_data: got %h want 00", DataWrSW); else passCnt++;
    totalCnt++; if ({Wr, Rd} !== 2'b00) $display("FAIL rst_strobes: got %b want 00", {Wr, Rd}); else passCnt++;
    PciReset = 1'b1;
    tick(1'b1, 4'hF);
    $display("reset released at cycle %0d", cycleNo);
  endtask

  task automatic test_write;
    int s;
    Event e, o;
    doWrite(16'h0708, 8'hA5, s);
    totalCnt++; if (obsQ.size() !== 1) $display("FAIL wr_count: got %0d want 1", obsQ.size()); else passCnt++;
    if (obsQ.size() > 0 && expQ.size() > 0) begin
      e = expQ.pop_front(); o = obsQ.pop_front();
      $display("write addr=%h data=%h cyc=%0d", o.addr, o.data, o.cyc);
      totalCnt++; if (o.isWr !== e.isWr) $display("FAIL wr_kind: got %b want %b", o.isWr, e.isWr); else passCnt++;
      totalCnt++; if (o.addr !== e.addr) $display("FAIL wr_addr: got %h want %h", o.addr, e.addr); else passCnt++;
      totalCnt++; if (o.data !== e.data) $display("FAIL wr_data: got %h want %h", o.data, e.data); else passCnt++;
      totalCnt++; if (o.cyc !== e.cyc) $display("FAIL wr_cycle: got %0d want %0d", o.cyc, e.cyc); else passCnt++;
    end
    totalCnt++; if ({oeTrace[s+9], ladTrace[s+9]} !== 5'b1_0000) $display("FAIL wr_sync: got %b/%h want 1/0", oeTrace[s+9], ladTrace[s+9]); else passCnt++;
    totalCnt++; if ({oeTrace[s+10], ladTrace[s+10]} !== 5'b1_1111) $display("FAIL wr_ttar0: got %b/%h want 1/f", oeTrace[s+10], ladTrace[s+10]); else passCnt++;
    totalCnt++; if (oeTrace[s+11] !== 1'b0) $display("FAIL wr_ttar1_oe: got %b want 0", oeTrace[s+11]); else passCnt++;
    totalCnt++; if (oeCount(s, s + 12) !== 2) $display("FAIL wr_oe_len: got %0d want 2", oeCount(s, s + 12)); else passCnt++;
  endtask

  task automatic test_read;
    int s;
    Event e, o;
    logic [7:0] v;
    v = 8'h3C;
    regFile[8'h00] = v;
    doRead(16'h0700, 13, s);
    totalCnt++; if (obsQ.size() !== 1) $display("FAIL rd_count: got %0d want 1", obsQ.size()); else passCnt++;
    if (obsQ.size() > 0 && expQ.size() > 0) begin
      e = expQ.pop_front(); o = obsQ.pop_front();
      $display("read addr=%h cyc=%0d lad=%h %h %h %h", o.addr, o.cyc, ladTrace[s+7], ladTrace[s+8], ladTrace[s+9], ladTrace[s+10]);
      totalCnt++; if (o.isWr !== e.isWr) $display("FAIL rd_kind: got %b want %b", o.isWr, e.isWr); else passCnt++;
      totalCnt++; if (o.addr !== e.addr) $display("FAIL rd_addr: got %h want %h", o.addr, e.addr); else passCnt++;
      totalCnt++; if (o.cyc !== e.cyc) $display("FAIL rd_cycle: got %0d want %0d", o.cyc, e.cyc); else passCnt++;
    end
    totalCnt++; if (ladTrace[s+7] !== 4'h0) $display("FAIL rd_sync: got %h want 0", ladTrace[s+7]); else passCnt++;
    totalCnt++; if (ladTrace[s+8] !== v[3:0]) $display("FAIL rd_lo: got %h want %h", ladTrace[s+8], v[3:0]); else passCnt++;
    totalCnt++; if (ladTrace[s+9] !== v[7:4]) $display("FAIL rd_hi: got %h want %h", ladTrace[s+9], v[7:4]); else passCnt++;
    totalCnt++; if (ladTrace[s+10] !== 4'hF) $display("FAIL rd_ttar0: got %h want f", ladTrace[s+10]); else passCnt++;
    totalCnt++; if (oeCount(s, s + 12) !== 4) $display("FAIL rd_oe_len: got %0d want 4", oeCount(s, s + 12)); else passCnt++;
    totalCnt++; if (oeTrace[s+11] !== 1'b0) $display("FAIL rd_ttar1_oe: got %b want 0", oeTrace[s+11]); else passCnt++;
  endtask

  task automatic test_miss;
    int s, s2;
    doWrite(16'h0800, 8'h77, s);
    s2 = cycleNo + 1;
    tick(1'b0, 4'h0);
    tick(1'b1, 4'h4);
    repeat (4) tick(1'b1, 4'h0);
    repeat (7) tick(1'b1, 4'hF);
    $display("miss+mem done at cycle %0d strobes=%0d", cycleNo, obsQ.size());
    totalCnt++; if (obsQ.size() !== 0) $display("FAIL miss_strobes: got %0d want 0", obsQ.size()); else passCnt++;
    totalCnt++; if (oeCount(s, cycleNo) !== 0) $display("FAIL miss_oe: got %0d want 0", oeCount(s, cycleNo)); else passCnt++;
    totalCnt++; if (Addr !== lastAddr) $display("FAIL miss_addr: got %h want %h", Addr, lastAddr); else passCnt++;
    totalCnt++; if (DataWrSW !== lastData) $display("FAIL miss_data: got %h want %h", DataWrSW, lastData); else passCnt++;
    obsQ.delete();
  endtask

  task automatic test_abort;
    int s, s2;
    Event e, o;
    s = cycleNo + 1;
    tick(1'b0, 4'h0);
    tick(1'b1, 4'h2);
    tick(1'b1, 4'h0);
    tick(1'b1, 4'h7);
    tick(1'b0, 4'hF);
    repeat (8) tick(1'b1, 4'hF);
    $display("abort done at cycle %0d strobes=%0d", cycleNo, obsQ.size());
    totalCnt++; if (obsQ.size() !== 0) $display("FAIL abort_strobes: got %0d want 0", obsQ.size()); else passCnt++;
    totalCnt++; if (oeCount(s, cycleNo) !== 0) $display("FAIL abort_oe: got %0d want 0", oeCount(s, cycleNo)); else passCnt++;
    obsQ.delete();
    doWrite(16'h071F, 8'h5A, s2);
    totalCnt++; if (obsQ.size() !== 1) $display("FAIL post_abort_count: got %0d want 1", obsQ.size()); else passCnt++;
    if (obsQ.size() > 0 && expQ.size() > 0) begin
      e = expQ.pop_front(); o = obsQ.pop_front();
      $display("write addr=%h data=%h cyc=%0d", o.addr, o.data, o.cyc);
      totalCnt++; if (o.addr !== e.addr) $display("FAIL post_abort_addr: got %h want %h", o.addr, e.addr); else passCnt++;
      totalCnt++; if (o.data !== e.data) $display("FAIL post_abort_data: got %h want %h", o.data, e.data); else passCnt++;
      totalCnt++; if (o.cyc !== e.cyc) $display("FAIL post_abort_cycle: got %0d want %0d", o.cyc, e.cyc); else passCnt++;
    end
  endtask

  task automatic test_reset_mid;
    int s, s2;
    Event e, o;
    regFile[8'h05] = 8'h96;
    doRead(16'h0705, 10, s);
    totalCnt++; if (ladTrace[s+8] !== 4'h6) $display("FAIL mid_rdata0: got %h want 6", ladTrace[s+8]); else passCnt++;
    PciReset = 1'b0;
    #1;
    totalCnt++; if (LAD_OE !== 1'b0) $display("FAIL mid_rst_oe: got %b want 0", LAD_OE); else passCnt++;
    totalCnt++; if (LAD_O !== 4'hF) $display("FAIL mid_rst_lad: got %h want f", LAD_O); else passCnt++;
    totalCnt++; if ({Addr, DataWrSW} !== 16'h0000) $display("FAIL mid_rst_regs: got %h want 0000", {Addr, DataWrSW}); else passCnt++;
    if (obsQ.size() > 0 && expQ.size() > 0) begin
      e = expQ.pop_front(); o = obsQ.pop_front();
      totalCnt++; if (o.cyc !== e.cyc) $display("FAIL mid_rd_cycle: got %0d want %0d", o.cyc, e.cyc); else passCnt++;
    end
    lastAddr = 8'h00;
    lastData = 8'h00;
    tick(1'b1, 4'hF);
    PciReset = 1'b1;
    tick(1'b1, 4'hF);
    $display("mid-read reset at cycle %0d", s + 9);
    doRead(16'h0705, 13, s2);
    if (obsQ.size() > 0 && expQ.size() > 0) begin
      e = expQ.pop_front(); o = obsQ.pop_front();
      $display("read addr=%h cyc=%0d", o.addr, o.cyc);
      totalCnt++; if (o.addr !== e.addr) $display("FAIL rerd_addr: got %h want %h", o.addr, e.addr); else passCnt++;
    end
    totalCnt++; if ({ladTrace[s2+8], ladTrace[s2+9]} !== 8'h69) $display("FAIL rerd_data: got %h want 69", {ladTrace[s2+8], ladTrace[s2+9]}); else passCnt++;
    totalCnt++; if (oeCount(s2, s2 + 12) !== 4) $display("FAIL rerd_oe_len: got %0d want 4", oeCount(s2, s2 + 12)); else passCnt++;
  endtask

  task automatic test_back_to_back;
    int s1, s2;
    Event e, o;
    int wrCyc[2];
    doWrite(16'h0701, 8'h11, s1);
    doWrite(16'h0702, 8'h22, s2);
    totalCnt++; if (obsQ.size() !== 2) $display("FAIL b2b_count: got %0d want 2", obsQ.size()); else passCnt++;
    for (int k = 0; k < 2; k++) begin
      if (obsQ.size() > 0 && expQ.size() > 0) begin
        e = expQ.pop_front(); o = obsQ.pop_front();
        wrCyc[k] = o.cyc;
        $display("write addr=%h data=%h cyc=%0d", o.addr, o.data, o.cyc);
        totalCnt++; if (o.addr !== e.addr) $display("FAIL b2b_addr%0d: got %h want %h", k, o.addr, e.addr); else passCnt++;
        totalCnt++; if (o.data !== e.data) $display("FAIL b2b_data%0d: got %h want %h", k, o.data, e.data); else passCnt++;
        totalCnt++; if (o.cyc !== e.cyc) $display("FAIL b2b_cycle%0d: got %0d want %0d", k, o.cyc, e.cyc); else passCnt++;
      end else begin
        wrCyc[k] = 0;
      end
    end
    totalCnt++; if (wrCyc[1] - wrCyc[0] !== 13) $display("FAIL b2b_spacing: got %0d want 13", wrCyc[1] - wrCyc[0]); else passCnt++;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) regFile[i] = 8'(i);
    test_reset;
    test_write;
    test_read;
    test_miss;
    test_abort;
    test_reset_mid;
    test_back_to_back;
    totalCnt++; if (expQ.size() !== 0) $display("FAIL leftover_expected: got %0d want 0", expQ.size()); else passCnt++;
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
